// File: rtl/ysyx_trap_pkg.sv
// Shared types and constants for the EXU trap/CSR sequencer.
package ysyx_trap_pkg;

    localparam int YSYX_W_WIDTH = 32;

    localparam logic [11:0] CSR_MNONE   = 12'h000;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int CAUSE_ECALL_M = 11;
    localparam int MSTATUS_MIE   = 3;
    localparam int MSTATUS_MPIE  = 7;

    typedef enum logic [2:0] {
        OP_CSRRW = 3'd0,
        OP_CSRRS = 3'd1,
        OP_CSRRC = 3'd2,
        OP_ECALL = 3'd3,
        OP_MRET  = 3'd4
    } trap_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } trap_state_e;

endpackage

// File: rtl/ysyx_csr_alu.sv
// Combinational CSR write-port generator for one system instruction.
module ysyx_csr_alu
    import ysyx_trap_pkg::*;
#(
    parameter int XLEN = YSYX_W_WIDTH,
    parameter int R_W  = 12
) (
    input  logic [2:0]      op,
    input  logic [R_W-1:0]  addr,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] src,
    input  logic            src_zero,
    input  logic [XLEN-1:0] pc,
    output logic [R_W-1:0]  waddr0,
    output logic [R_W-1:0]  waddr1,
    output logic [XLEN-1:0] wdata0,
    output logic [XLEN-1:0] wdata1,
    output logic            wen,
    output logic            ecall,
    output logic            redir,
    output logic [XLEN-1:0] rdata
);

    // Addresses are kept in their own block: old is read back through
    // waddr0, so mixing them with the data path would form a false loop.
    always_comb begin
        waddr0 = R_W'(CSR_MNONE);
        waddr1 = R_W'(CSR_MNONE);
        unique case (1'b1)
            (op == OP_CSRRW),
            (op == OP_CSRRS),
            (op == OP_CSRRC): waddr0 = addr;
            (op == OP_ECALL): begin
                waddr0 = R_W'(CSR_MCAUSE);
                waddr1 = R_W'(CSR_MEPC);
            end
            (op == OP_MRET):  waddr0 = R_W'(CSR_MSTATUS);
            default: ;
        endcase
    end

    always_comb begin
        wdata0 = '0;
        wdata1 = '0;
        wen    = 1'b0;
        ecall  = 1'b0;
        redir  = 1'b0;
        rdata  = '0;
        unique case (1'b1)
            (op == OP_CSRRW): begin
                wdata0 = src;
                wen    = 1'b1;
                rdata  = old;
            end
            (op == OP_CSRRS): begin
                wdata0 = old | src;
                wen    = !src_zero;
                rdata  = old;
            end
            (op == OP_CSRRC): begin
                wdata0 = old & ~src;
                wen    = !src_zero;
                rdata  = old;
            end
            (op == OP_ECALL): begin
                wdata0 = XLEN'(CAUSE_ECALL_M);
                wdata1 = pc;
                wen    = 1'b1;
                ecall  = 1'b1;
                redir  = 1'b1;
            end
            (op == OP_MRET): begin
                wdata0               = old;
                wdata0[MSTATUS_MIE]  = old[MSTATUS_MPIE];
                wdata0[MSTATUS_MPIE] = 1'b1;
                wen                  = 1'b1;
                redir                = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_exu_trap.sv
// System-instruction sequencer in front of the CSR file: IDLE -> EXEC -> RESP.
module ysyx_exu_trap
    import ysyx_trap_pkg::*;
#(
    parameter int XLEN = YSYX_W_WIDTH,
    parameter int R_W  = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_src,
    input  logic            in_src_zero,
    input  logic [R_W-1:0]  in_csr_addr,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] csr_rdata_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    output logic            csr_wen_o,
    output logic            csr_valid_o,
    output logic            csr_ecall_o,
    output logic [R_W-1:0]  csr_waddr0_o,
    output logic [R_W-1:0]  csr_waddr1_o,
    output logic [XLEN-1:0] csr_wdata0_o,
    output logic [XLEN-1:0] csr_wdata1_o,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_rdata,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc
);

    trap_state_e state_q, state_d;

    logic [2:0]      op_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] src_q;
    logic            src_zero_q;
    logic [R_W-1:0]  addr_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] redir_pc_q;
    logic            need_redir_q;
    logic            out_done_q;
    logic            redir_done_q;

    logic [R_W-1:0]  alu_waddr0, alu_waddr1;
    logic [XLEN-1:0] alu_wdata0, alu_wdata1, alu_rdata;
    logic            alu_wen, alu_ecall, alu_redir;

    logic exec, resp, accept, out_fire, redir_fire, all_done;

    ysyx_csr_alu #(
        .XLEN(XLEN),
        .R_W (R_W)
    ) u_alu (
        .op      (op_q),
        .addr    (addr_q),
        .old     (csr_rdata_i),
        .src     (src_q),
        .src_zero(src_zero_q),
        .pc      (pc_q),
        .waddr0  (alu_waddr0),
        .waddr1  (alu_waddr1),
        .wdata0  (alu_wdata0),
        .wdata1  (alu_wdata1),
        .wen     (alu_wen),
        .ecall   (alu_ecall),
        .redir   (alu_redir),
        .rdata   (alu_rdata)
    );

    // rst gates EXEC combinationally so an aborted op never writes.
    assign exec = (state_q == ST_EXEC) && !rst;
    assign resp = (state_q == ST_RESP) && !rst;

    assign csr_valid_o  = exec;
    assign csr_wen_o    = exec && alu_wen;
    assign csr_ecall_o  = exec && alu_ecall;
    assign csr_waddr0_o = exec ? alu_waddr0 : '0;
    assign csr_waddr1_o = exec ? alu_waddr1 : '0;
    assign csr_wdata0_o = exec ? alu_wdata0 : '0;
    assign csr_wdata1_o = exec ? alu_wdata1 : '0;

    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        redir_valid = 1'b0;
        out_rd      = '0;
        out_rdata   = '0;
        redir_pc    = '0;
        accept      = 1'b0;
        out_fire    = 1'b0;
        redir_fire  = 1'b0;
        all_done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = !rst;
                accept   = in_valid && !rst;
                if (accept) state_d = ST_EXEC;
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                out_valid   = resp && !out_done_q;
                redir_valid = resp && need_redir_q && !redir_done_q;
                out_rd      = rd_q;
                out_rdata   = rdata_q;
                redir_pc    = redir_pc_q;
                out_fire    = out_valid && out_ready;
                redir_fire  = redir_valid && redir_ready;
                all_done    = (out_done_q || out_fire) &&
                              (!need_redir_q || redir_done_q || redir_fire);
                if (all_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= '0;
            pc_q         <= '0;
            src_q        <= '0;
            src_zero_q   <= 1'b0;
            addr_q       <= '0;
            rd_q         <= '0;
            rdata_q      <= '0;
            redir_pc_q   <= '0;
            need_redir_q <= 1'b0;
            out_done_q   <= 1'b0;
            redir_done_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= in_op;
                pc_q       <= in_pc;
                src_q      <= in_src;
                src_zero_q <= in_src_zero;
                addr_q     <= in_csr_addr;
                rd_q       <= in_rd;
            end
            if (state_q == ST_EXEC) begin
                rdata_q      <= alu_rdata;
                need_redir_q <= alu_redir;
                out_done_q   <= 1'b0;
                redir_done_q <= 1'b0;
                if (alu_redir) rd_q <= '0;
                if (op_q == OP_ECALL)     redir_pc_q <= csr_mtvec_i;
                else if (op_q == OP_MRET) redir_pc_q <= csr_mepc_i;
                else                      redir_pc_q <= '0;
            end
            if (out_fire)   out_done_q   <= 1'b1;
            if (redir_fire) redir_done_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_exu_trap.sv
// Scoreboard bench for ysyx_exu_trap with a small CSR file model.
module tb_ysyx_exu_trap;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_pc, in_src;
    logic        in_src_zero;
    logic [11:0] in_csr_addr;
    logic [4:0]  in_rd;
    logic [31:0] csr_rdata_i, csr_mtvec_i, csr_mepc_i;
    logic        csr_wen_o, csr_valid_o, csr_ecall_o;
    logic [11:0] csr_waddr0_o, csr_waddr1_o;
    logic [31:0] csr_wdata0_o, csr_wdata1_o;
    logic        out_valid, out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_rdata;
    logic        redir_valid, redir_ready;
    logic [31:0] redir_pc;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        full;
        logic        wen;
        logic        ecall;
        logic [11:0] a0, a1;
        logic [31:0] d0, d1;
    } exp_exec_t;

    typedef struct {
        logic        chk_data;
        logic [4:0]  rd;
        logic [31:0] rdata;
    } exp_out_t;

    exp_exec_t   q_exec[$];
    exp_out_t    q_out[$];
    logic [31:0] q_redir[$];

    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

    ysyx_exu_trap dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_pc       (in_pc),
        .in_src      (in_src),
        .in_src_zero (in_src_zero),
        .in_csr_addr (in_csr_addr),
        .in_rd       (in_rd),
        .csr_rdata_i (csr_rdata_i),
        .csr_mtvec_i (csr_mtvec_i),
        .csr_mepc_i  (csr_mepc_i),
        .csr_wen_o   (csr_wen_o),
        .csr_valid_o (csr_valid_o),
        .csr_ecall_o (csr_ecall_o),
        .csr_waddr0_o(csr_waddr0_o),
        .csr_waddr1_o(csr_waddr1_o),
        .csr_wdata0_o(csr_wdata0_o),
        .csr_wdata1_o(csr_wdata1_o),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rd      (out_rd),
        .out_rdata   (out_rdata),
        .redir_valid (redir_valid),
        .redir_ready (redir_ready),
        .redir_pc    (redir_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        csr_rdata_i = '0;
        case (csr_waddr0_o)
            12'h300: csr_rdata_i = m_mstatus;
            12'h305: csr_rdata_i = m_mtvec;
            12'h341: csr_rdata_i = m_mepc;
            12'h342: csr_rdata_i = m_mcause;
            default: csr_rdata_i = '0;
        endcase
    end
    assign csr_mtvec_i = m_mtvec;
    assign csr_mepc_i  = m_mepc;

    task automatic mwrite(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: m_mstatus <= d;
            12'h305: m_mtvec   <= d;
            12'h341: m_mepc    <= d;
            12'h342: m_mcause  <= d;
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_mstatus <= '0;
            m_mtvec   <= '0;
            m_mepc    <= '0;
            m_mcause  <= '0;
        end else if (csr_wen_o) begin
            mwrite(csr_waddr0_o, csr_wdata0_o);
            mwrite(csr_waddr1_o, csr_wdata1_o);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    exp_exec_t me;
    exp_out_t  mo;
    logic [31:0] mr;

    always @(negedge clk) begin
        if (!rst) begin
            if (csr_valid_o) begin
                if (q_exec.size() == 0) begin
                    chk("exec_unexpected", 1, 0);
                end else begin
                    me = q_exec.pop_front();
                    chk("exec_wen", csr_wen_o, me.wen);
                    chk("exec_ecall", csr_ecall_o, me.ecall);
                    if (me.full) begin
                        chk("exec_waddr0", csr_waddr0_o, me.a0);
                        chk("exec_wdata0", csr_wdata0_o, me.d0);
                        chk("exec_waddr1", csr_waddr1_o, me.a1);
                        chk("exec_wdata1", csr_wdata1_o, me.d1);
                    end
                end
            end else if (csr_wen_o) begin
                chk("wen_outside_exec", 1, 0);
            end
            if (out_valid && out_ready) begin
                if (q_out.size() == 0) begin
                    chk("out_unexpected", 1, 0);
                end else begin
                    mo = q_out.pop_front();
                    chk("out_rd", out_rd, mo.rd);
                    if (mo.chk_data) chk("out_rdata", out_rdata, mo.rdata);
                end
            end
            if (redir_valid && redir_ready) begin
                if (q_redir.size() == 0) begin
                    chk("redir_unexpected", 1, 0);
                end else begin
                    mr = q_redir.pop_front();
                    chk("redir_pc", redir_pc, mr);
                end
            end
        end
    end

    task automatic push_exec(input logic full, input logic wen,
                             input logic ecall, input logic [11:0] a0,
                             input logic [31:0] d0, input logic [11:0] a1,
                             input logic [31:0] d1);
        exp_exec_t e;
        e.full = full; e.wen = wen; e.ecall = ecall;
        e.a0 = a0; e.d0 = d0; e.a1 = a1; e.d1 = d1;
        q_exec.push_back(e);
    endtask

    task automatic push_out(input logic cd, input logic [4:0] rd,
                            input logic [31:0] rdata);
        exp_out_t o;
        o.chk_data = cd; o.rd = rd; o.rdata = rdata;
        q_out.push_back(o);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] pc,
                         input logic [31:0] src, input logic z,
                         input logic [11:0] a, input logic [4:0] rd);
        int n;
        in_valid = 1'b1; in_op = op; in_pc = pc; in_src = src;
        in_src_zero = z; in_csr_addr = a; in_rd = rd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) chk("issue_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_pc = 32'hdead_beef; in_src = 32'hffff_ffff;
        in_csr_addr = 12'hfff; in_rd = 5'h1f; in_op = 3'd0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) chk("idle_timeout", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_pc = '0; in_src = '0;
        in_src_zero = 1'b0; in_csr_addr = '0; in_rd = '0;
        out_ready = 1'b1; redir_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_valids", {out_valid, redir_valid, csr_valid_o, csr_wen_o,
                           csr_ecall_o}, 0);
        chk("rst_addr", {csr_waddr0_o, csr_waddr1_o}, 0);
        chk("rst_wdata", csr_wdata0_o | csr_wdata1_o, 0);
        chk("rst_resp_data", out_rdata | redir_pc | 32'(out_rd), 0);
        @(posedge clk); #1;

        push_exec(1, 1, 0, 12'h305, 32'h8000_0100, 12'h000, 0);
        push_out(1, 5'd5, 32'h0);
        issue(3'd0, 32'h0, 32'h8000_0100, 0, 12'h305, 5'd5); wait_idle();

        push_exec(1, 1, 0, 12'h300, 32'h8, 12'h000, 0);
        push_out(1, 5'd1, 32'h0);
        issue(3'd0, 32'h0, 32'h8, 0, 12'h300, 5'd1); wait_idle();

        push_exec(1, 1, 0, 12'h300, 32'h88, 12'h000, 0);
        push_out(1, 5'd6, 32'h8);
        issue(3'd1, 32'h0, 32'h80, 0, 12'h300, 5'd6); wait_idle();

        push_exec(1, 0, 0, 12'h300, 32'h88, 12'h000, 0);
        push_out(1, 5'd7, 32'h88);
        issue(3'd2, 32'h0, 32'h0, 1, 12'h300, 5'd7); wait_idle();

        push_exec(1, 1, 1, 12'h342, 32'd11, 12'h341, 32'h8000_0040);
        push_out(0, 5'd0, 0);
        q_redir.push_back(32'h8000_0100);
        issue(3'd3, 32'h8000_0040, 32'h0, 1, 12'h000, 5'd9); wait_idle();

        push_exec(1, 1, 0, 12'h341, 32'h8000_0044, 12'h000, 0);
        push_out(1, 5'd8, 32'h8000_0040);
        issue(3'd0, 32'h0, 32'h8000_0044, 0, 12'h341, 5'd8); wait_idle();

        push_exec(1, 1, 0, 12'h300, 32'h80, 12'h000, 0);
        push_out(1, 5'd10, 32'h88);
        issue(3'd0, 32'h0, 32'h80, 0, 12'h300, 5'd10); wait_idle();

        push_exec(1, 1, 0, 12'h300, 32'h88, 12'h000, 0);
        push_out(0, 5'd0, 0);
        q_redir.push_back(32'h8000_0044);
        issue(3'd4, 32'h0, 32'h0, 1, 12'h000, 5'd11); wait_idle();

        redir_ready = 1'b0;
        push_exec(1, 1, 1, 12'h342, 32'd11, 12'h341, 32'h8000_0050);
        push_out(0, 5'd0, 0);
        q_redir.push_back(32'h8000_0100);
        issue(3'd3, 32'h8000_0050, 32'h0, 1, 12'h000, 5'd12);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp1_redir_valid", redir_valid, 1);
            chk("bp1_redir_pc", redir_pc, 32'h8000_0100);
            chk("bp1_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        redir_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp1_return_idle", in_ready, 1);
        @(posedge clk); #1;

        out_ready = 1'b0;
        push_exec(1, 1, 1, 12'h342, 32'd11, 12'h341, 32'h8000_0060);
        push_out(0, 5'd0, 0);
        q_redir.push_back(32'h8000_0100);
        issue(3'd3, 32'h8000_0060, 32'h0, 1, 12'h000, 5'd13);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp2_out_valid", out_valid, 1);
            chk("bp2_out_rd", out_rd, 0);
            chk("bp2_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp2_return_idle", in_ready, 1);
        @(posedge clk); #1;

        push_exec(0, 0, 0, 12'h000, 0, 12'h000, 0);
        push_out(1, 5'd3, 32'h0);
        issue(3'd5, 32'h0, 32'h1234, 0, 12'h305, 5'd3); wait_idle();

        issue(3'd0, 32'h0, 32'h1234_5678, 0, 12'h305, 5'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wen", csr_wen_o, 0);
        chk("abort_valid", csr_valid_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_outs", {out_valid, redir_valid, csr_valid_o,
                           csr_wen_o}, 0);
        chk("abort_data", out_rdata | redir_pc | csr_wdata0_o, 0);
        @(posedge clk); #1;
        push_exec(1, 0, 0, 12'h305, 32'h0, 12'h000, 0);
        push_out(1, 5'd4, 32'h0);
        issue(3'd1, 32'h0, 32'h0, 1, 12'h305, 5'd4); wait_idle();

        repeat (3) @(posedge clk);
        chk("q_exec_empty", q_exec.size(), 0);
        chk("q_out_empty", q_out.size(), 0);
        chk("q_redir_empty", q_redir.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
